// File: rtl/axis_frame_packetizer_if.sv
// AXI4-Stream bundle used on both sides of the frame packetizer.
// The slave view leaves out tkeep because the capture stream always carries full words.
`timescale 1ns/1ps

interface axis_frame_packetizer_if;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_frame_packetizer.sv
// Buffers captured 64-bit AXI beats in a FIFO and emits headered frames toward the MAC/UDP stage.
// A frame closes on the size limit, on an idle timeout, or after an upstream tlast word.
// Header word layout: {HEADER_MAGIC, seq[15:0], len[15:0], 16'h0000}.
`timescale 1ns/1ps

module axis_frame_packetizer #(
    parameter int          FIFO_DEPTH        = 512,
    parameter int          MAX_PAYLOAD_WORDS = 180,
    parameter int          TIMEOUT_CYCLES    = 1000,
    parameter logic [15:0] HEADER_MAGIC      = 16'hE7A0
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    axis_frame_packetizer_if.slave        s_axis,
    axis_frame_packetizer_if.master       m_axis,
    output logic [31:0]                   frame_count,
    output logic [31:0]                   stall_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD
    } state_t;

    logic [63:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wrPtr_q;
    logic [PTR_W-1:0]   rdPtr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;

    state_t             state_q;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   remaining_q;
    logic [TIMER_W-1:0] timer_q;
    logic [15:0]        seq_q;
    logic               flushPending_q;
    logic               ready_q;
    logic               outValid_q;
    logic               outLast_q;
    logic [63:0]        outData_q;
    logic [31:0]        frameCount_q;
    logic [31:0]        stallCount_q;

    logic               full;
    logic               inReady;
    logic               wrEn;
    logic               rdEn;
    logic               trigger;
    logic [CNT_W-1:0]   frameLen;

    // ready_q keeps the input closed during reset and opens it one cycle after release
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign inReady  = ready_q && !full;
    assign wrEn     = s_axis.tvalid && inReady;
    assign rdEn     = (state_q == PAYLOAD) && outValid_q && m_axis.tready;

    assign frameLen = (count_q >= CNT_W'(MAX_PAYLOAD_WORDS)) ? CNT_W'(MAX_PAYLOAD_WORDS) : count_q;
    assign trigger  = (state_q == IDLE) &&
                      ((count_q >= CNT_W'(MAX_PAYLOAD_WORDS)) ||
                       ((count_q != '0) && flushPending_q) ||
                       ((count_q != '0) && (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1))));

    assign s_axis.tready = inReady;
    assign m_axis.tdata  = outData_q;
    assign m_axis.tkeep  = 8'hFF;
    assign m_axis.tvalid = outValid_q;
    assign m_axis.tlast  = outLast_q;
    assign frame_count   = frameCount_q;
    assign stall_count   = stallCount_q;

    // Occupancy after this cycle's write and pop, also used to decide whether a flush is done
    always_comb begin
        count_d = count_q;
        if (wrEn && !rdEn) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wrEn && rdEn) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Payload storage; left unreset since pointers and occupancy define what is valid
    always_ff @(posedge aclk) begin
        if (wrEn) begin
            mem[wrPtr_q] <= s_axis.tdata;
        end
    end

    // FIFO pointers wrap naturally at the power-of-two depth
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (wrEn) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (rdEn) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Input ready enable, low in reset and high from the first edge after release
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Cycles where the capture block offered a beat we could not take; saturates
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stallCount_q <= '0;
        end else if (s_axis.tvalid && !inReady && (stallCount_q != 32'hFFFF_FFFF)) begin
            stallCount_q <= stallCount_q + 32'd1;
        end
    end

    // Frame FSM with registered header/payload output, idle timer and flush tracking
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q        <= IDLE;
            len_q          <= '0;
            remaining_q    <= '0;
            timer_q        <= '0;
            seq_q          <= '0;
            flushPending_q <= 1'b0;
            outValid_q     <= 1'b0;
            outLast_q      <= 1'b0;
            outData_q      <= '0;
            frameCount_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        len_q      <= frameLen;
                        timer_q    <= '0;
                        outData_q  <= {HEADER_MAGIC, seq_q, 16'(frameLen), 16'h0000};
                        outValid_q <= 1'b1;
                        outLast_q  <= 1'b0;
                        state_q    <= HEADER;
                    end else if ((count_q == '0) || wrEn) begin
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                HEADER: begin
                    if (m_axis.tready) begin
                        remaining_q <= len_q;
                        outData_q   <= mem[rdPtr_q];
                        outLast_q   <= (len_q == CNT_W'(1));
                        state_q     <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (m_axis.tready) begin
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            outValid_q   <= 1'b0;
                            outLast_q    <= 1'b0;
                            seq_q        <= seq_q + 16'd1;
                            frameCount_q <= frameCount_q + 32'd1;
                            state_q      <= IDLE;
                        end else begin
                            outData_q <= mem[rdPtr_q + PTR_W'(1)];
                            outLast_q <= (remaining_q == CNT_W'(2));
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    outValid_q <= 1'b0;
                    outLast_q  <= 1'b0;
                end
            endcase

            if (wrEn && s_axis.tlast) begin
                flushPending_q <= 1'b1;
            end else if (rdEn && (remaining_q == CNT_W'(1)) && (count_d == '0)) begin
                flushPending_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_frame_packetizer.sv
// Directed bench for axis_frame_packetizer with the default parameters.
// Expected frames come from the words this bench sends and the documented header layout.
`timescale 1ns/1ps

module tb_axis_frame_packetizer;

    typedef struct packed {
        logic        last;
        logic [63:0] data;
    } beat_t;

    logic        aclk;
    logic        aresetn;
    logic [31:0] frame_count;
    logic [31:0] stall_count;

    axis_frame_packetizer_if sIf ();
    axis_frame_packetizer_if mIf ();

    axis_frame_packetizer dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s_axis      (sIf),
        .m_axis      (mIf),
        .frame_count (frame_count),
        .stall_count (stall_count)
    );

    int    checks    = 0;
    int    errors    = 0;
    int    stableErr = 0;
    int    readyMode = 1;
    beat_t rxQ[$];

    logic        prevHold = 1'b0;
    logic [63:0] prevData = '0;
    logic        prevLast = 1'b0;

    // Free-running 100 MHz clock
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Output sink: drives m tready for the next edge, records handshakes, and watches
    // that a stalled output word stays put until it is accepted
    always @(negedge aclk) begin
        case (readyMode)
            0:       mIf.tready = 1'b0;
            1:       mIf.tready = 1'b1;
            default: mIf.tready = 1'($urandom_range(0, 1));
        endcase
        if (!aresetn) begin
            prevHold = 1'b0;
        end else begin
            if (prevHold && !(mIf.tvalid && (mIf.tdata == prevData) && (mIf.tlast == prevLast))) begin
                stableErr++;
            end
            if (mIf.tvalid && mIf.tready) begin
                rxQ.push_back({mIf.tlast, mIf.tdata});
            end
            prevHold = mIf.tvalid && !mIf.tready;
            prevData = mIf.tdata;
            prevLast = mIf.tlast;
        end
    end

    // Guard against a hung run
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts the check and reports any mismatch
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Sends n consecutive words base, base+1, ... with optional tlast on the final one
    task automatic applyStimulus(input logic [63:0] base, input int n, input bit lastOnFinal);
        int waitC;
        for (int i = 0; i < n; i++) begin
            waitC = 0;
            sIf.tvalid = 1'b1;
            sIf.tdata  = base + 64'(i);
            sIf.tlast  = lastOnFinal && (i == n - 1);
            while (!sIf.tready && (waitC < 20000)) begin
                @(negedge aclk);
                waitC++;
            end
            if (!sIf.tready) begin
                checkOutput("push ready", 64'(sIf.tready), 64'd1);
                break;
            end
            @(negedge aclk);
        end
        sIf.tvalid = 1'b0;
        sIf.tlast  = 1'b0;
    endtask

    // Waits, with a cycle budget, until at least n output beats have been recorded
    task automatic waitWords(input int n, input int budget, output bit ok);
        int c;
        c = 0;
        while ((rxQ.size() < n) && (c < budget)) begin
            @(negedge aclk);
            c++;
        end
        ok = (rxQ.size() >= n);
    endtask

    // Next recorded beat, or zero when nothing arrived
    function automatic beat_t popBeat();
        beat_t b;
        b = '0;
        if (rxQ.size() > 0) begin
            b = rxQ.pop_front();
        end
        return b;
    endfunction

    // Pulls one frame from the sink and compares header and payload against expectations
    task automatic checkFrame(input string tag, input logic [15:0] seq, input int len, input logic [63:0] base);
        bit    ok;
        beat_t b;
        int    bad;
        waitWords(len + 1, 5000, ok);
        checkOutput({tag, " arrive"}, 64'(ok), 64'd1);
        b = popBeat();
        checkOutput({tag, " header"}, b.data, {16'hE7A0, seq, 16'(len), 16'h0000});
        checkOutput({tag, " header last"}, 64'(b.last), 64'd0);
        bad = 0;
        for (int i = 0; i < len; i++) begin
            b = popBeat();
            if (b.data !== base + 64'(i)) bad++;
            if (b.last !== (i == len - 1)) bad++;
        end
        checkOutput({tag, " payload errors"}, 64'(bad), 64'd0);
        repeat (2) @(negedge aclk);
    endtask

    // Directed sequence: reset, steady, timeout, flush, burst, backpressure, seq wrap, reset mid-frame
    initial begin
        bit ok;
        int cycles;

        aresetn    = 1'b0;
        sIf.tvalid = 1'b0;
        sIf.tdata  = '0;
        sIf.tlast  = 1'b0;
        sIf.tkeep  = 8'hFF;
        readyMode  = 1;

        repeat (3) @(negedge aclk);
        checkOutput("reset m tvalid", 64'(mIf.tvalid), 64'd0);
        checkOutput("reset m tlast", 64'(mIf.tlast), 64'd0);
        checkOutput("reset m tdata", mIf.tdata, 64'd0);
        checkOutput("reset s tready", 64'(sIf.tready), 64'd0);
        checkOutput("reset frame_count", 64'(frame_count), 64'd0);
        checkOutput("reset stall_count", 64'(stall_count), 64'd0);
        aresetn = 1'b1;
        #1;
        checkOutput("release s tready low", 64'(sIf.tready), 64'd0);
        @(negedge aclk);
        checkOutput("release s tready high", 64'(sIf.tready), 64'd1);
        checkOutput("tkeep", 64'(mIf.tkeep), 64'hFF);

        $display("[TB] steady stream of 180 words");
        applyStimulus(64'd0, 180, 1'b0);
        checkFrame("steady", 16'h0000, 180, 64'd0);
        checkOutput("steady frame_count", 64'(frame_count), 64'd1);

        // Header becomes visible on the 1000th edge after the 5th write edge
        $display("[TB] idle timeout with 5 words");
        applyStimulus(64'h1000, 5, 1'b0);
        cycles = 0;
        while (!mIf.tvalid && (cycles < 3000)) begin
            @(negedge aclk);
            cycles++;
        end
        checkOutput("timeout latency", 64'(cycles), 64'd1000);
        checkFrame("timeout", 16'h0001, 5, 64'h1000);
        checkOutput("timeout frame_count", 64'(frame_count), 64'd2);

        $display("[TB] tlast flush of 3 words");
        applyStimulus(64'h2000, 3, 1'b1);
        cycles = 0;
        while (!mIf.tvalid && (cycles < 3000)) begin
            @(negedge aclk);
            cycles++;
        end
        checkOutput("flush latency", 64'(cycles), 64'd1);
        checkFrame("flush", 16'h0002, 3, 64'h2000);
        checkOutput("flush frame_count", 64'(frame_count), 64'd3);

        $display("[TB] 400 word burst ending in tlast");
        applyStimulus(64'h3000, 400, 1'b1);
        checkFrame("burst0", 16'h0003, 180, 64'h3000);
        checkFrame("burst1", 16'h0004, 180, 64'h3000 + 64'd180);
        checkFrame("burst2", 16'h0005, 40, 64'h3000 + 64'd360);
        checkOutput("burst frame_count", 64'(frame_count), 64'd6);

        // 512 writes fill the FIFO, the remaining 88 offered cycles are stalls
        $display("[TB] backpressure with 600 words");
        readyMode = 0;
        repeat (2) @(negedge aclk);
        fork
            applyStimulus(64'h4000, 600, 1'b0);
            begin
                repeat (600) @(negedge aclk);
                checkOutput("bp stall_count", 64'(stall_count), 64'd88);
                checkOutput("bp s tready", 64'(sIf.tready), 64'd0);
                readyMode = 2;
            end
        join
        checkFrame("bp0", 16'h0006, 180, 64'h4000);
        checkFrame("bp1", 16'h0007, 180, 64'h4000 + 64'd180);
        checkFrame("bp2", 16'h0008, 180, 64'h4000 + 64'd360);
        checkFrame("bp3", 16'h0009, 60, 64'h4000 + 64'd540);
        checkOutput("bp stable output", 64'(stableErr), 64'd0);
        checkOutput("bp frame_count", 64'(frame_count), 64'd10);
        readyMode = 1;
        repeat (2) @(negedge aclk);

        $display("[TB] sequence number wrap");
        force dut.seq_q = 16'hFFFF;
        @(negedge aclk);
        release dut.seq_q;
        applyStimulus(64'h5000, 360, 1'b0);
        checkFrame("wrap0", 16'hFFFF, 180, 64'h5000);
        checkFrame("wrap1", 16'h0000, 180, 64'h5000 + 64'd180);
        checkOutput("wrap frame_count", 64'(frame_count), 64'd12);

        $display("[TB] reset in the middle of a frame");
        applyStimulus(64'h6000, 180, 1'b0);
        waitWords(51, 2000, ok);
        checkOutput("rst reach word 50", 64'(ok), 64'd1);
        aresetn = 1'b0;
        #1;
        checkOutput("rst m tvalid", 64'(mIf.tvalid), 64'd0);
        checkOutput("rst m tlast", 64'(mIf.tlast), 64'd0);
        checkOutput("rst m tdata", mIf.tdata, 64'd0);
        checkOutput("rst s tready", 64'(sIf.tready), 64'd0);
        checkOutput("rst frame_count", 64'(frame_count), 64'd0);
        checkOutput("rst stall_count", 64'(stall_count), 64'd0);
        rxQ.delete();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        #1;
        checkOutput("rst release s tready low", 64'(sIf.tready), 64'd0);
        @(negedge aclk);
        checkOutput("rst release s tready high", 64'(sIf.tready), 64'd1);
        applyStimulus(64'h7000, 3, 1'b1);
        checkFrame("post reset", 16'h0000, 3, 64'h7000);
        checkOutput("post reset frame_count", 64'(frame_count), 64'd1);
        checkOutput("post reset leftovers", 64'(rxQ.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
